free_list: RTL and testbench

Physical-register free list for the out-of-order pipeline. It is a 32-entry circular FIFO of 6-bit physical register numbers (PR#) that sits beside the map table at dispatch:
- Dispatch pops a fresh PR for each destination-writing instruction.
- Retire pushes the superseded PR (the reorder buffer's `PR_old_RT`) back.
- Branch/jump recovery undoes allocations by rewinding the head, once per flushed ROB entry, in youngest-first order.

---
 rtl/free_list.sv | 80 ++++++++
 tb/tb_free_list.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list: a circular FIFO of free PR numbers that is popped at
// dispatch, pushed at retire, and rewound one entry per flushed ROB entry on recovery.
module free_list #(
    parameter int DEPTH = 32,
    parameter int PR_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hasDest_DP,
    output logic [PR_W-1:0]          PR_new_DP,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt,
    input  logic                     RegDest_retire,
    input  logic [PR_W-1:0]          PR_old_RT,
    input  logic                     stall_recover,
    input  logic                     recover,
    input  logic [4:0]               rd_flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PR_W-1:0]  mem_q [DEPTH];
    logic [PR_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, alloc, ret, undo;

    // Undo needs no write: the slot behind head still holds the PR handed to the flushed entry.
    always_comb begin
        full   = (cnt_q == CNT_W'(DEPTH));
        alloc  = hasDest_DP && (cnt_q != '0) && !recover && !stall_recover;
        ret    = RegDest_retire && (PR_old_RT != '0) && !full;
        undo   = recover && (rd_flush != '0) && !full;
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (alloc) begin
            head_d = head_q + PTR_W'(1);
        end else if (undo) begin
            head_d = head_q - PTR_W'(1);
        end
        if (ret) begin
            mem_d[tail_q] = PR_old_RT;
            tail_d        = tail_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(ret) + CNT_W'(undo) - CNT_W'(alloc);
    end

    // Architectural registers own P0..P(DEPTH-1) at reset, so the list holds the upper half.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PR_W'(DEPTH + i);
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CNT_W'(DEPTH);
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(full && ((RegDest_retire && (PR_old_RT != '0)) ||
                               (recover && (rd_flush != '0)))))
            else $info("free_list: return or undo dropped while list is full");
        end
    end

    assign PR_new_DP = mem_q[head_q];
    assign empty     = (cnt_q == '0);
    assign free_cnt  = cnt_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: each task drives one scenario and checks the
// offered PR, empty flag and free count against hand-derived values.
module tb_free_list;

    logic       clk;
    logic       rst;
    logic       hasDest_DP;
    logic [5:0] PR_new_DP;
    logic       empty;
    logic [5:0] free_cnt;
    logic       RegDest_retire;
    logic [5:0] PR_old_RT;
    logic       stall_recover;
    logic       recover;
    logic [4:0] rd_flush;

    int n_cmp = 0;
    int n_bad = 0;

    free_list #(.DEPTH(32), .PR_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .hasDest_DP     (hasDest_DP),
        .PR_new_DP      (PR_new_DP),
        .empty          (empty),
        .free_cnt       (free_cnt),
        .RegDest_retire (RegDest_retire),
        .PR_old_RT      (PR_old_RT),
        .stall_recover  (stall_recover),
        .recover        (recover),
        .rd_flush       (rd_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hasDest_DP     = 1'b0;
        RegDest_retire = 1'b0;
        PR_old_RT      = 6'd0;
        stall_recover  = 1'b0;
        recover        = 1'b0;
        rd_flush       = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (PR_new_DP !== 6'd32) begin n_bad++; $display("[TB] FAIL reset_pr: got %0d expected 32", PR_new_DP); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_empty: got %0b expected 0", empty); end
        n_cmp++; if (free_cnt !== 6'd32) begin n_bad++; $display("[TB] FAIL reset_cnt: got %0d expected 32", free_cnt); end
    endtask

    task automatic test_alloc_all();
        do_reset();
        hasDest_DP = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            n_cmp++; if (PR_new_DP !== 6'(32 + i)) begin n_bad++; $display("[TB] FAIL alloc_seq[%0d]: got %0d expected %0d", i, PR_new_DP, 32 + i); end
            tick();
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("[TB] FAIL alloc_empty: got %0b expected 1", empty); end
        n_cmp++; if (free_cnt !== 6'd0) begin n_bad++; $display("[TB] FAIL alloc_cnt0: got %0d expected 0", free_cnt); end
        tick();
        n_cmp++; if (free_cnt !== 6'd0) begin n_bad++; $display("[TB] FAIL alloc_33_cnt: got %0d expected 0", free_cnt); end
        n_cmp++; if (PR_new_DP !== 6'd32) begin n_bad++; $display("[TB] FAIL alloc_33_head: got %0d expected 32", PR_new_DP); end
    endtask

    // Continues from the empty state left by test_alloc_all.
    task automatic test_empty_return();
        hasDest_DP     = 1'b1;
        RegDest_retire = 1'b1;
        PR_old_RT      = 6'd40;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("[TB] FAIL empty_ret_empty: got %0b expected 0", empty); end
        n_cmp++; if (free_cnt !== 6'd1) begin n_bad++; $display("[TB] FAIL empty_ret_cnt: got %0d expected 1", free_cnt); end
        n_cmp++; if (PR_new_DP !== 6'd40) begin n_bad++; $display("[TB] FAIL empty_ret_pr: got %0d expected 40", PR_new_DP); end
    endtask

    task automatic test_recovery();
        logic [4:0] flush_seq [3];
        logic [5:0] exp_pr    [3];
        logic [5:0] exp_cnt   [3];
        flush_seq = '{5'd5, 5'd0, 5'd7};
        exp_pr    = '{6'd34, 6'd34, 6'd33};
        exp_cnt   = '{6'd30, 6'd30, 6'd31};
        do_reset();
        hasDest_DP = 1'b1;
        repeat (3) tick();
        n_cmp++; if (PR_new_DP !== 6'd35) begin n_bad++; $display("[TB] FAIL rec_pre_pr: got %0d expected 35", PR_new_DP); end
        n_cmp++; if (free_cnt !== 6'd29) begin n_bad++; $display("[TB] FAIL rec_pre_cnt: got %0d expected 29", free_cnt); end
        stall_recover = 1'b1;
        rd_flush      = 5'd3;
        tick();
        n_cmp++; if (free_cnt !== 6'd29) begin n_bad++; $display("[TB] FAIL rec_stall_cnt: got %0d expected 29", free_cnt); end
        n_cmp++; if (PR_new_DP !== 6'd35) begin n_bad++; $display("[TB] FAIL rec_stall_pr: got %0d expected 35", PR_new_DP); end
        stall_recover = 1'b0;
        recover       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_flush = flush_seq[i];
            tick();
            n_cmp++; if (PR_new_DP !== exp_pr[i]) begin n_bad++; $display("[TB] FAIL rec_undo_pr[%0d]: got %0d expected %0d", i, PR_new_DP, exp_pr[i]); end
            n_cmp++; if (free_cnt !== exp_cnt[i]) begin n_bad++; $display("[TB] FAIL rec_undo_cnt[%0d]: got %0d expected %0d", i, free_cnt, exp_cnt[i]); end
        end
        recover  = 1'b0;
        rd_flush = 5'd0;
        tick();
        n_cmp++; if (PR_new_DP !== 6'd34) begin n_bad++; $display("[TB] FAIL rec_resume_pr: got %0d expected 34", PR_new_DP); end
        n_cmp++; if (free_cnt !== 6'd30) begin n_bad++; $display("[TB] FAIL rec_resume_cnt: got %0d expected 30", free_cnt); end
        idle_inputs();
    endtask

    task automatic test_undo_with_retire();
        do_reset();
        hasDest_DP = 1'b1;
        repeat (4) tick();
        hasDest_DP = 1'b0;
        n_cmp++; if (free_cnt !== 6'd28) begin n_bad++; $display("[TB] FAIL undo_ret_pre_cnt: got %0d expected 28", free_cnt); end
        recover        = 1'b1;
        rd_flush       = 5'd3;
        RegDest_retire = 1'b1;
        PR_old_RT      = 6'd12;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (free_cnt !== 6'd30) begin n_bad++; $display("[TB] FAIL undo_ret_cnt: got %0d expected 30", free_cnt); end
        n_cmp++; if (PR_new_DP !== 6'd35) begin n_bad++; $display("[TB] FAIL undo_ret_pr: got %0d expected 35", PR_new_DP); end
        // Slots 3..31 still hold 35..63; slot 0 must now hold P12.
        hasDest_DP = 1'b1;
        for (int i = 0; i < 29; i++) begin
            #1;
            n_cmp++; if (PR_new_DP !== 6'(35 + i)) begin n_bad++; $display("[TB] FAIL undo_ret_drain[%0d]: got %0d expected %0d", i, PR_new_DP, 35 + i); end
            tick();
        end
        hasDest_DP = 1'b0;
        #1;
        n_cmp++; if (PR_new_DP !== 6'd12) begin n_bad++; $display("[TB] FAIL undo_ret_slot0: got %0d expected 12", PR_new_DP); end
        n_cmp++; if (free_cnt !== 6'd1) begin n_bad++; $display("[TB] FAIL undo_ret_end_cnt: got %0d expected 1", free_cnt); end
    endtask

    task automatic test_illegal_return();
        do_reset();
        hasDest_DP = 1'b1;
        tick();
        hasDest_DP     = 1'b0;
        RegDest_retire = 1'b1;
        PR_old_RT      = 6'd0;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (free_cnt !== 6'd31) begin n_bad++; $display("[TB] FAIL ret_p0_cnt: got %0d expected 31", free_cnt); end
        n_cmp++; if (PR_new_DP !== 6'd33) begin n_bad++; $display("[TB] FAIL ret_p0_pr: got %0d expected 33", PR_new_DP); end
        do_reset();
        RegDest_retire = 1'b1;
        PR_old_RT      = 6'd50;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (free_cnt !== 6'd32) begin n_bad++; $display("[TB] FAIL ret_full_cnt: got %0d expected 32", free_cnt); end
        n_cmp++; if (PR_new_DP !== 6'd32) begin n_bad++; $display("[TB] FAIL ret_full_pr: got %0d expected 32", PR_new_DP); end
        // A dropped push must not have moved tail: the next legal push lands in slot 0.
        hasDest_DP = 1'b1;
        tick();
        hasDest_DP     = 1'b0;
        RegDest_retire = 1'b1;
        PR_old_RT      = 6'd45;
        tick();
        idle_inputs();
        hasDest_DP = 1'b1;
        repeat (31) tick();
        hasDest_DP = 1'b0;
        #1;
        n_cmp++; if (PR_new_DP !== 6'd45) begin n_bad++; $display("[TB] FAIL ret_full_tail: got %0d expected 45", PR_new_DP); end
        n_cmp++; if (free_cnt !== 6'd1) begin n_bad++; $display("[TB] FAIL ret_full_tail_cnt: got %0d expected 1", free_cnt); end
    endtask

    task automatic test_wrap_reset();
        logic [5:0] q [$];
        logic [5:0] v;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            v = 6'(32 + i);
            q.push_back(v);
        end
        hasDest_DP = 1'b1;
        for (int i = 0; i < 4; i++) begin
            void'(q.pop_front());
            tick();
        end
        RegDest_retire = 1'b1;
        for (int i = 0; i < 36; i++) begin
            PR_old_RT = 6'(1 + i);
            #1;
            n_cmp++; if (PR_new_DP !== q[0]) begin n_bad++; $display("[TB] FAIL wrap_pr[%0d]: got %0d expected %0d", i, PR_new_DP, q[0]); end
            void'(q.pop_front());
            q.push_back(PR_old_RT);
            tick();
            n_cmp++; if (free_cnt !== 6'd28) begin n_bad++; $display("[TB] FAIL wrap_cnt[%0d]: got %0d expected 28", i, free_cnt); end
        end
        hasDest_DP = 1'b0;
        for (int j = 0; j < 2; j++) begin
            PR_old_RT = 6'(37 + j);
            q.push_back(PR_old_RT);
            tick();
        end
        n_cmp++; if (free_cnt !== 6'd30) begin n_bad++; $display("[TB] FAIL wrap_tail_cnt: got %0d expected 30", free_cnt); end
        n_cmp++; if (PR_new_DP !== q[0]) begin n_bad++; $display("[TB] FAIL wrap_order: got %0d expected %0d", PR_new_DP, q[0]); end
        // Reset lands in the middle of further push traffic and must win over it.
        PR_old_RT  = 6'd39;
        hasDest_DP = 1'b1;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_cmp++; if (PR_new_DP !== 6'd32) begin n_bad++; $display("[TB] FAIL wrap_rst_pr: got %0d expected 32", PR_new_DP); end
        n_cmp++; if (free_cnt !== 6'd32) begin n_bad++; $display("[TB] FAIL wrap_rst_cnt: got %0d expected 32", free_cnt); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_rst_empty: got %0b expected 0", empty); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_alloc_all();
        test_empty_return();
        test_recovery();
        test_undo_with_retire();
        test_illegal_return();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
